// File: rtl/gate_tt_pkg.sv
// gate_tt_pkg: shared types and constants for the gate truth-table sequencer.
//   state_t      sequencer FSM states (IDLE, DRIVE, FINISH)
//   tt_width()   truth-table width for an n-input gate (2**n)
//   TT_*         expected tables for 2-input gates; bit i = y for input vector i
//   TIMER_W      width of the settle down-counter (SETTLE range 0..255)
package gate_tt_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DRIVE  = 2'd1,
    FINISH = 2'd2
  } state_t;

  localparam int unsigned TIMER_W = 8;

  localparam logic [3:0] TT_NOR  = 4'b0001;
  localparam logic [3:0] TT_AND  = 4'b1000;
  localparam logic [3:0] TT_OR   = 4'b1110;
  localparam logic [3:0] TT_NAND = 4'b0111;

  function automatic int unsigned tt_width(input int unsigned n);
    return 32'd1 << n;
  endfunction

endpackage

// File: rtl/tt_settle_timer.sv
// tt_settle_timer: down-counter that times the hold window of each applied vector.
//   clk       rising-edge clock
//   rst_n     asynchronous active-low reset
//   load      reload the counter with load_val (start of a vector)
//   load_val  number of extra hold cycles before the sample edge
//   expired   counter is at zero: the next edge is the sample edge
module tt_settle_timer
  import gate_tt_pkg::*;
(
  input  logic               clk,
  input  logic               rst_n,
  input  logic               load,
  input  logic [TIMER_W-1:0] load_val,
  output logic               expired
);

  logic [TIMER_W-1:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (cnt != '0) begin
      cnt <= cnt - 1'b1;
    end
  end

  assign expired = (cnt == '0);

endmodule

// File: rtl/gate_tt_sequencer.sv
// gate_tt_sequencer: exhaustive truth-table driver/checker for small combinational gates.
// Steps gate_in through 0..2**N_IN-1, holds each vector SETTLE+1 cycles, samples gate_y on
// the last cycle and compares it against the table captured at start.
//   clk, rst_n   clock (rising edge) and asynchronous active-low reset
//   start        1-cycle sweep request; ignored unless idle
//   exp_tt       expected truth table, captured when start is accepted
//   gate_y       output of the gate under test
//   gate_in      vector driven to the gate (equals vec_idx)
//   vec_idx      index currently applied / last sampled
//   busy, done   sweep in progress / 1-cycle completion pulse
//   pass         every sample matched (valid from done until next start)
//   fail_mask    bit i set = vector i mismatched (valid from done until next start)
// Build option: define TT_STOP_ON_FAIL_EN to end the sweep on the first mismatch.
module gate_tt_sequencer
  import gate_tt_pkg::*;
#(
  parameter int unsigned         N_IN   = 2,
  parameter int unsigned         SETTLE = 2,
  parameter logic [2**N_IN-1:0]  EXP_TT = TT_NOR
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  input  logic [2**N_IN-1:0]  exp_tt,
  input  logic                gate_y,
  output logic [N_IN-1:0]     gate_in,
  output logic [N_IN-1:0]     vec_idx,
  output logic                busy,
  output logic                done,
  output logic                pass,
  output logic [2**N_IN-1:0]  fail_mask
);

  localparam int unsigned          TT_W      = tt_width(N_IN);
  localparam logic [N_IN-1:0]      LAST_IDX  = N_IN'(TT_W - 1);
  localparam logic [TIMER_W-1:0]   SETTLE_LD = TIMER_W'(SETTLE);

  state_t            state;
  logic [TT_W-1:0]   exp_tab;
  logic              expired;
  logic              sample;
  logic              mismatch;
  logic              stop;
  logic              load;
  logic [TT_W-1:0]   mask_next;

  always_comb begin
    sample    = (state == DRIVE) && expired;
    mismatch  = (gate_y != exp_tab[vec_idx]);
    mask_next = fail_mask | (TT_W'(mismatch) << vec_idx);
`ifdef TT_STOP_ON_FAIL_EN
    stop      = (vec_idx == LAST_IDX) || mismatch;
`else
    stop      = (vec_idx == LAST_IDX);
`endif
    // Reload on sweep start and whenever the sequencer moves on to the next vector.
    load      = ((state == IDLE) && start) || (sample && !stop);
  end

  tt_settle_timer u_timer (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (load),
    .load_val (SETTLE_LD),
    .expired  (expired)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      exp_tab   <= EXP_TT;
      gate_in   <= '0;
      vec_idx   <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      pass      <= 1'b0;
      fail_mask <= '0;
    end else begin
      done <= 1'b0;
      unique case (state)
        IDLE: begin
          if (start) begin
            state     <= DRIVE;
            exp_tab   <= exp_tt;
            fail_mask <= '0;
            vec_idx   <= '0;
            gate_in   <= '0;
            busy      <= 1'b1;
            pass      <= 1'b0;
          end
        end
        DRIVE: begin
          if (sample) begin
            fail_mask <= mask_next;
            if (stop) begin
              // vec_idx is left on the last sampled vector
              state <= FINISH;
              done  <= 1'b1;
              busy  <= 1'b0;
              pass  <= ~|mask_next;
            end else begin
              vec_idx <= vec_idx + 1'b1;
              gate_in <= vec_idx + 1'b1;
            end
          end
        end
        FINISH: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_gate_tt_sequencer.sv
// tb_gate_tt_sequencer: scoreboard bench for gate_tt_sequencer (N_IN=2, SETTLE=2).
// The gate under test is a truth-table lookup driven from gate_in. Each issued sweep pushes
// its expected completion (cycle, pass, mask, final index) derived from exp ^ gate table.
module tb_gate_tt_sequencer;
  import gate_tt_pkg::*;

  localparam int unsigned N_IN   = 2;
  localparam int unsigned SETTLE = 2;
  localparam int unsigned TT_W   = 4;
  localparam int          PER    = SETTLE + 1;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [3:0]  exp_tt = TT_NOR;
  logic [3:0]  gate_tab = TT_NOR;
  logic        gate_y;
  logic [1:0]  gate_in;
  logic [1:0]  vec_idx;
  logic        busy;
  logic        done;
  logic        pass;
  logic [3:0]  fail_mask;

  assign gate_y = gate_tab[gate_in];

  gate_tt_sequencer #(
    .N_IN   (N_IN),
    .SETTLE (SETTLE),
    .EXP_TT (TT_NOR)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .exp_tt    (exp_tt),
    .gate_y    (gate_y),
    .gate_in   (gate_in),
    .vec_idx   (vec_idx),
    .busy      (busy),
    .done      (done),
    .pass      (pass),
    .fail_mask (fail_mask)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int         a;     // acceptance edge
    int         d;     // edge after which done is high
    logic       pass;
    logic [3:0] mask;
    logic [1:0] idx;
  } exp_t;

  exp_t sb[$];
  int   n_vec = 0;
  int   n_bad = 0;

  bit         hold_valid = 1'b0;
  logic       hold_pass;
  logic [3:0] hold_mask;
  logic [1:0] hold_idx;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
    n_vec++;
    if (act !== want) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, want, cyc);
    end
  endtask

  // Monitor: pops an expectation on every done pulse; checks progress while busy.
  always @(negedge clk) begin : mon
    exp_t e;
    int   n;
    if (rst_n && done) begin
      if (sb.size() == 0) begin
        chk("unexpected_done", 32'd1, 32'd0);
      end else begin
        e = sb.pop_front();
        chk("done_cycle", 32'(cyc), 32'(e.d));
        chk("pass", 32'(pass), 32'(e.pass));
        chk("fail_mask", 32'(fail_mask), 32'(e.mask));
        chk("vec_idx_final", 32'(vec_idx), 32'(e.idx));
        chk("busy_at_done", 32'(busy), 32'd0);
        hold_valid = 1'b1;
        hold_pass  = e.pass;
        hold_mask  = e.mask;
        hold_idx   = e.idx;
      end
    end else if (rst_n && sb.size() != 0) begin
      e = sb[0];
      n = cyc - e.a;
      if (n >= 0 && cyc < e.d) begin
        chk("busy", 32'(busy), 32'd1);
        chk("gate_in", 32'(gate_in), 32'(n / PER));
        chk("vec_idx", 32'(vec_idx), 32'(n / PER));
      end
    end else if (rst_n && hold_valid) begin
      chk("hold_pass", 32'(pass), 32'(hold_pass));
      chk("hold_mask", 32'(fail_mask), 32'(hold_mask));
      chk("hold_idx", 32'(vec_idx), 32'(hold_idx));
      chk("idle_busy", 32'(busy), 32'd0);
    end
  end

  // Issue one sweep; optionally re-pulse start mid-sweep, on the last sample edge and in FINISH.
  task automatic sweep(input logic [3:0] e, input logic [3:0] t, input bit poke);
    exp_t       x;
    logic [3:0] full;
    int         nv;
    full = e ^ t;
    nv   = TT_W;
    x.idx  = 2'(TT_W - 1);
    x.mask = full;
`ifdef TT_STOP_ON_FAIL_EN
    begin
      int f;
      f = -1;
      for (int i = 0; i < TT_W; i++) if (full[i] && f < 0) f = i;
      if (f >= 0) begin
        nv     = f + 1;
        x.idx  = 2'(f);
        x.mask = 4'(1 << f);
      end
    end
`endif
    x.pass = (x.mask == 4'd0);
    @(negedge clk);
    #2;
    gate_tab   = t;
    exp_tt     = e;
    start      = 1'b1;
    hold_valid = 1'b0;
    x.a = cyc + 1;
    x.d = x.a + nv * PER;
    sb.push_back(x);
    for (int k = 0; k < nv * PER + 4; k++) begin
      @(negedge clk);
      #2;
      start  = poke && (cyc == x.a + 3 || cyc == x.d - 1 || cyc == x.d);
      exp_tt = 4'($urandom);
    end
    start = 1'b0;
    chk("done_seen", 32'(sb.size()), 32'd0);
    sb.delete();
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_gate_in"}, 32'(gate_in), 32'd0);
    chk({tag, "_vec_idx"}, 32'(vec_idx), 32'd0);
    chk({tag, "_busy"}, 32'(busy), 32'd0);
    chk({tag, "_done"}, 32'(done), 32'd0);
    chk({tag, "_pass"}, 32'(pass), 32'd0);
    chk({tag, "_fail_mask"}, 32'(fail_mask), 32'd0);
  endtask

  // Abort a sweep with reset between edges 6 and 7; no done may follow.
  task automatic reset_mid_sweep();
    exp_t x;
    @(negedge clk);
    #2;
    gate_tab   = TT_NOR;
    exp_tt     = TT_NOR;
    start      = 1'b1;
    hold_valid = 1'b0;
    x.a = cyc + 1;
    x.d = x.a + TT_W * PER;
    x.pass = 1'b1;
    x.mask = 4'd0;
    x.idx  = 2'd3;
    sb.push_back(x);
    @(negedge clk);
    #2;
    start = 1'b0;
    while (cyc < x.a + 6) begin
      @(negedge clk);
      #2;
    end
    rst_n = 1'b0;
    #1;
    sb.delete();
    hold_valid = 1'b0;
    check_reset_outputs("abort");
    repeat (3) @(negedge clk);
    #2;
    rst_n = 1'b1;
    for (int k = 0; k < 2 * TT_W * PER; k++) begin
      @(negedge clk);
      chk("no_done_after_abort", 32'(done), 32'd0);
    end
  endtask

  initial begin
    repeat (3) @(negedge clk);
    check_reset_outputs("reset");
    #2;
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    sweep(TT_NOR, TT_NOR, 1'b0);
    sweep(TT_NOR, TT_AND, 1'b0);
    sweep(TT_NOR, TT_NOR, 1'b1);
    reset_mid_sweep();
    sweep(TT_NOR, TT_NOR, 1'b0);
    sweep(TT_OR, TT_OR, 1'b0);
    sweep(TT_NAND, TT_AND, 1'b1);
    sweep(TT_AND, TT_NAND, 1'b0);

    for (int r = 0; r < 40; r++) begin
      logic [3:0] e;
      logic [3:0] t;
      e = 4'($urandom);
      t = ($urandom_range(0, 1) == 0) ? e : 4'($urandom);
      sweep(e, t, bit'($urandom_range(0, 1)));
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end

    repeat (3) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
